// File: rtl/key_press_classifier.sv
// Synchronises, debounces and classifies one active-low push-button into short/long/double events.
// Optional auto-repeat while held past long is built only when KEY_CLASS_REPEAT_EN is defined.
module key_press_classifier #(
  parameter int DEB_CYCLES    = 120000,
  parameter int LONG_CYCLES   = 9000000,
  parameter int GAP_CYCLES    = 3000000,
  parameter int REPEAT_CYCLES = 1200000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key,
  output logic       o_level,
  output logic       o_short,
  output logic       o_long,
  output logic       o_double,
  output logic       o_repeat,
  output logic [2:0] o_state
);

  localparam int MAX_LG = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int MAX_P  = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P + 1);
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);

  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } state_t;

  logic             r_sync1, r_sync2;
  logic [DEB_W-1:0] r_deb_cnt;
  logic             r_level, r_level_d;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short, r_long, r_double;
  logic             w_press, w_release;
  logic [CNT_W-1:0] w_cnt_inc;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  // Resetting to 0 makes the synchroniser read "released" until the pin is sampled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~i_key;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_deb_cnt <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_level   <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_press   = r_level & ~r_level_d;
  assign w_release = ~r_level & r_level_d;
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  // Release/press edges win over a threshold reached in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle so each event lasts exactly one clock.
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_double <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_press) r_state <= PRESS1;
        end
        PRESS1: begin
          if (w_release) begin
            r_state <= GAP;
            r_cnt   <= '0;
          end else if (r_cnt == LONG_LAST) begin
            r_long  <= 1'b1;
            r_state <= HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        GAP: begin
          if (w_press) begin
            r_state <= PRESS2;
            r_cnt   <= '0;
          end else if (r_cnt == GAP_LAST) begin
            r_short <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        PRESS2: begin
          if (w_release) begin
            r_double <= 1'b1;
            r_state  <= IDLE;
            r_cnt    <= '0;
          end else if (r_cnt == LONG_LAST) begin
            r_long  <= 1'b1;
            r_state <= HELD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        HELD: begin
          r_cnt <= '0;
          if (w_release) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KEY_CLASS_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_repeat;

  // Counts only while HELD, so the first pulse lands REPEAT_CYCLES after the long pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rep_cnt <= '0;
      r_repeat  <= 1'b0;
    end else begin
      r_repeat <= 1'b0;
      if (r_state != HELD || w_release) begin
        r_rep_cnt <= '0;
      end else if (r_rep_cnt == REP_LAST) begin
        r_repeat  <= 1'b1;
        r_rep_cnt <= '0;
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  assign o_repeat = r_repeat;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_level  = r_level;
  assign o_short  = r_short;
  assign o_long   = r_long;
  assign o_double = r_double;
  assign o_state  = r_state;

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomised and directed bench for key_press_classifier against a timestamp/schedule reference model.
module tb_key_press_classifier;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int GAP  = 10;
  localparam int REP  = 8;

  localparam int K_NONE   = 0;
  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_DOUBLE = 3;
  localparam int K_REPEAT = 4;

`ifdef KEY_CLASS_REPEAT_EN
  localparam int EXP_REPEATS = 2;
`else
  localparam int EXP_REPEATS = 0;
`endif

  logic       i_clk   = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_key   = 1'b1;
  logic       o_level, o_short, o_long, o_double, o_repeat;
  logic [2:0] o_state;

  int checks = 0;
  int errors = 0;

  // Reference model: debounced level plus a single pending-event schedule
  int       m_t, m_run, m_phase, exp_t, exp_k, m_state_exp;
  bit       m_level, k1, k2;
  logic [3:0] m_pulse;

  int n_short, n_long, n_double, n_repeat, n_rise;
  int t_rise, t_fall, t_short, t_long, t_double;
  bit prev_level;

  key_press_classifier #(
    .DEB_CYCLES   (DEB),
    .LONG_CYCLES  (LONG),
    .GAP_CYCLES   (GAP),
    .REPEAT_CYCLES(REP)
  ) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_key   (i_key),
    .o_level (o_level),
    .o_short (o_short),
    .o_long  (o_long),
    .o_double(o_double),
    .o_repeat(o_repeat),
    .o_state (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at t=%0d", tag, got, exp, m_t);
    end
  endtask

  task automatic model_reset();
    m_t         = 0;
    m_run       = 0;
    m_phase     = 0;
    exp_t       = 0;
    exp_k       = K_NONE;
    m_state_exp = 0;
    m_level     = 1'b0;
    k1          = 1'b1;
    k2          = 1'b1;
    m_pulse     = '0;
  endtask

  task automatic model_edge(input bit raw);
    bit s, rise, fall;
    m_t++;
    s  = ~k2;
    k2 = k1;
    k1 = raw;
    rise = 1'b0;
    fall = 1'b0;
    if (s == m_level) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DEB) begin
        m_level = s;
        m_run   = 0;
        rise    = s;
        fall    = ~s;
      end
    end
    m_pulse = '0;
    if (exp_k != K_NONE && m_t == exp_t) begin
      m_pulse[exp_k-1] = 1'b1;
      case (exp_k)
        K_SHORT:  begin m_phase = 0; exp_k = K_NONE; end
        K_DOUBLE: exp_k = K_NONE;
        K_LONG: begin
          m_phase = 4;
`ifdef KEY_CLASS_REPEAT_EN
          exp_k = K_REPEAT;
          exp_t = m_t + REP;
`else
          exp_k = K_NONE;
`endif
        end
        K_REPEAT: exp_t = m_t + REP;
        default:  exp_k = K_NONE;
      endcase
    end
    m_state_exp = m_phase;
    if (rise) begin
      if (m_phase == 0) begin m_phase = 1; exp_k = K_LONG; exp_t = m_t + LONG + 1; end
      else if (m_phase == 2) begin m_phase = 3; exp_k = K_LONG; exp_t = m_t + LONG + 1; end
    end
    if (fall) begin
      if (m_phase == 1) begin m_phase = 2; exp_k = K_SHORT; exp_t = m_t + GAP + 1; end
      else if (m_phase == 3) begin m_phase = 0; exp_k = K_DOUBLE; exp_t = m_t + 1; end
      else if (m_phase == 4) begin m_phase = 0; exp_k = K_NONE; end
    end
  endtask

  task automatic step(input bit raw);
    logic [3:0] p;
    i_key = raw;
    @(posedge i_clk);
    model_edge(raw);
    @(negedge i_clk);
    p = {o_repeat, o_double, o_long, o_short};
    check("level", o_level, m_level);
    check("pulses", p, m_pulse);
    check("state", o_state, m_state_exp);
    check("exclusive", $countones(p) <= 1, 1);
    if (o_level && !prev_level) begin n_rise++; t_rise = m_t; end
    if (!o_level && prev_level) t_fall = m_t;
    prev_level = o_level;
    if (o_short)  begin n_short++;  t_short  = m_t; end
    if (o_long)   begin n_long++;   t_long   = m_t; end
    if (o_double) begin n_double++; t_double = m_t; end
    if (o_repeat) n_repeat++;
  endtask

  task automatic hold(input bit raw, input int n);
    for (int i = 0; i < n; i++) step(raw);
  endtask

  task automatic clr_stats();
    n_short = 0; n_long = 0; n_double = 0; n_repeat = 0; n_rise = 0;
    t_rise = 0; t_fall = 0; t_short = 0; t_long = 0; t_double = 0;
  endtask

  task automatic do_reset();
    i_key   = 1'b1;
    i_rst_n = 1'b0;
    #1;
    check("rst_level", o_level, 0);
    check("rst_pulses", {o_repeat, o_double, o_long, o_short}, 0);
    check("rst_state", o_state, 0);
    repeat (3) @(negedge i_clk);
    i_rst_n    = 1'b1;
    prev_level = 1'b0;
    model_reset();
  endtask

  initial begin
    bit raw;
    model_reset();
    clr_stats();
    repeat (2) @(negedge i_clk);
    do_reset();

    // Glitch shorter than the debounce window
    clr_stats();
    hold(1'b0, 3);
    hold(1'b1, 20);
    check("glitch_rise", n_rise, 0);
    check("glitch_pulses", n_short + n_long + n_double + n_repeat, 0);

    // Single short press
    clr_stats();
    hold(1'b0, 8);
    hold(1'b1, 25);
    check("short_cnt", n_short, 1);
    check("short_lat", t_short - t_fall, GAP + 1);
    check("short_other", n_long + n_double + n_repeat, 0);

    // Long press, held past the threshold
    clr_stats();
    hold(1'b0, 40);
    hold(1'b1, 30);
    check("long_cnt", n_long, 1);
    check("long_lat", t_long - t_rise, LONG + 1);
    check("long_short", n_short + n_double, 0);
    check("long_repeat", n_repeat, EXP_REPEATS);

    // Double press
    clr_stats();
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 25);
    check("dbl_cnt", n_double, 1);
    check("dbl_lat", t_double - t_fall, 1);
    check("dbl_short", n_short + n_long, 0);

    // Second press lands exactly when the gap counter reaches its last value
    clr_stats();
    hold(1'b0, 6);
    hold(1'b1, GAP);
    hold(1'b0, 6);
    hold(1'b1, 25);
    check("edge_dbl", n_double, 1);
    check("edge_short", n_short, 0);

    // One cycle later the gap has expired: two separate short presses
    clr_stats();
    hold(1'b0, 6);
    hold(1'b1, GAP + 1);
    hold(1'b0, 6);
    hold(1'b1, 25);
    check("late_short", n_short, 2);
    check("late_dbl", n_double, 0);

    // Reset in the middle of the second press
    clr_stats();
    hold(1'b0, 5);
    hold(1'b1, 5);
    hold(1'b0, 10);
    check("prst_state", o_state, 3);
    do_reset();
    clr_stats();
    hold(1'b1, 40);
    check("post_rst_pulses", n_short + n_long + n_double + n_repeat, 0);
    check("post_rst_rise", n_rise, 0);

    // Random gestures, glitches included
    raw = 1'b1;
    for (int seg = 0; seg < 60; seg++) begin
      raw = ~raw;
      hold(raw, $urandom_range(1, 30));
    end
    hold(1'b1, 40);
    check("final_idle", o_state, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
